// File: rtl/vfifo_multi_sc_pkg.sv
// Shared defaults and helpers for the single-clock multi-channel FIFO.
package vfifo_multi_sc_pkg;

    localparam int unsigned DefDataWidth  = 36;
    localparam int unsigned DefChWidth    = 3;
    localparam int unsigned DefDepthWidth = 5;
    localparam int unsigned DefAfullLvl   = 28;

    // Number of independent queues for a given channel-select width.
    function automatic int unsigned num_ch(input int unsigned ch_width);
        return 32'd1 << ch_width;
    endfunction

endpackage

// File: rtl/vfifo_multi_sc_ch_ctrl.sv
// Per-channel bookkeeping: pointers, fill count, status decode and sticky errors.
module vfifo_multi_sc_ch_ctrl
    import vfifo_multi_sc_pkg::*;
#(
    parameter int unsigned DEPTH_WIDTH = DefDepthWidth,
    parameter int unsigned AFULL_LVL   = DefAfullLvl
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic                   re_i,
    input  logic                   flush_i,
    output logic                   wr_acc_o,
    output logic                   rd_acc_o,
    output logic [DEPTH_WIDTH-1:0] wptr_o,
    output logic [DEPTH_WIDTH-1:0] rptr_o,
    output logic [DEPTH_WIDTH:0]   cnt_o,
    output logic                   full_o,
    output logic                   afull_o,
    output logic                   empty_o,
    output logic                   err_ovf_o,
    output logic                   err_udf_o
);

    localparam logic [DEPTH_WIDTH:0] FullCnt  = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] AfullCnt = (DEPTH_WIDTH + 1)'(AFULL_LVL);

    logic [DEPTH_WIDTH-1:0] wptr_q, wptr_d;
    logic [DEPTH_WIDTH-1:0] rptr_q, rptr_d;
    logic [DEPTH_WIDTH:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;
    logic                   full, empty;

    // Flags come from the registered count only, so they reflect the pre-edge state.
    assign full  = (cnt_q == FullCnt);
    assign empty = (cnt_q == '0);

    assign wr_acc_o  = we_i & ~full & ~flush_i;
    assign rd_acc_o  = re_i & ~empty & ~flush_i;
    assign wptr_o    = wptr_q;
    assign rptr_o    = rptr_q;
    assign cnt_o     = cnt_q;
    assign full_o    = full;
    assign afull_o   = (cnt_q >= AfullCnt);
    assign empty_o   = empty;
    assign err_ovf_o = ovf_q;
    assign err_udf_o = udf_q;

    // Next-state: flush wins over traffic; a flushed request is not an error.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q | (we_i & full & ~flush_i);
        udf_d  = udf_q | (re_i & empty & ~flush_i);
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_acc_o) wptr_d = wptr_q + DEPTH_WIDTH'(1);
            if (rd_acc_o) rptr_d = rptr_q + DEPTH_WIDTH'(1);
            case ({wr_acc_o, rd_acc_o})
                2'b10:   cnt_d = cnt_q + (DEPTH_WIDTH + 1)'(1);
                2'b01:   cnt_d = cnt_q - (DEPTH_WIDTH + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

endmodule

// File: rtl/vfifo_multi_sc.sv
// Single-clock multi-channel FIFO: NCH queues sharing one {channel, pointer} memory.
module vfifo_multi_sc
    import vfifo_multi_sc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned CH_WIDTH    = DefChWidth,
    parameter int unsigned DEPTH_WIDTH = DefDepthWidth,
    parameter int unsigned AFULL_LVL   = DefAfullLvl
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         wr_dat_i,
    input  logic                          wr_we_i,
    input  logic [CH_WIDTH-1:0]           wr_sel_i,
    input  logic                          rd_re_i,
    input  logic [CH_WIDTH-1:0]           rd_sel_i,
    output logic [DATA_WIDTH-1:0]         rd_dat_o,
    output logic                          rd_vld_o,
    output logic [CH_WIDTH-1:0]           rd_ch_o,
    input  logic [(2**CH_WIDTH)-1:0]      flush_i,
    output logic [(2**CH_WIDTH)-1:0]      fifo_full_o,
    output logic [(2**CH_WIDTH)-1:0]      fifo_afull_o,
    output logic [(2**CH_WIDTH)-1:0]      fifo_empty_o,
    input  logic [CH_WIDTH-1:0]           lvl_sel_i,
    output logic [DEPTH_WIDTH:0]          lvl_o,
    output logic [(2**CH_WIDTH)-1:0]      err_ovf_o,
    output logic [(2**CH_WIDTH)-1:0]      err_udf_o
);

    localparam int unsigned NCH    = num_ch(CH_WIDTH);
    localparam int unsigned AW     = CH_WIDTH + DEPTH_WIDTH;
    localparam int unsigned MemLen = 32'd1 << AW;

    logic [DATA_WIDTH-1:0]  mem [MemLen];
    logic [DEPTH_WIDTH-1:0] wptr [NCH];
    logic [DEPTH_WIDTH-1:0] rptr [NCH];
    logic [DEPTH_WIDTH:0]   cnt  [NCH];
    logic [NCH-1:0]         wr_acc_vec, rd_acc_vec;
    logic                   wr_acc, rd_acc;
    logic [AW-1:0]          waddr, raddr;

    logic [DATA_WIDTH-1:0]  rd_dat_q;
    logic                   rd_vld_q, rd_vld_d;
    logic [CH_WIDTH-1:0]    rd_ch_q, rd_ch_d;

    for (genvar g = 0; g < NCH; g++) begin : gen_ch
        vfifo_multi_sc_ch_ctrl #(
            .DEPTH_WIDTH (DEPTH_WIDTH),
            .AFULL_LVL   (AFULL_LVL)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .we_i      (wr_we_i && (wr_sel_i == CH_WIDTH'(g))),
            .re_i      (rd_re_i && (rd_sel_i == CH_WIDTH'(g))),
            .flush_i   (flush_i[g]),
            .wr_acc_o  (wr_acc_vec[g]),
            .rd_acc_o  (rd_acc_vec[g]),
            .wptr_o    (wptr[g]),
            .rptr_o    (rptr[g]),
            .cnt_o     (cnt[g]),
            .full_o    (fifo_full_o[g]),
            .afull_o   (fifo_afull_o[g]),
            .empty_o   (fifo_empty_o[g]),
            .err_ovf_o (err_ovf_o[g]),
            .err_udf_o (err_udf_o[g])
        );
    end

    // Only the selected channel can accept, so OR-reduction yields the single strobe.
    assign wr_acc = |wr_acc_vec;
    assign rd_acc = |rd_acc_vec;
    assign waddr  = {wr_sel_i, wptr[wr_sel_i]};
    assign raddr  = {rd_sel_i, rptr[rd_sel_i]};
    assign lvl_o  = cnt[lvl_sel_i];

    // Shared storage write port.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[waddr] <= wr_dat_i;
    end

    // Synchronous read port with output register, block-RAM friendly.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat_q <= '0;
        end else if (rd_acc) begin
            rd_dat_q <= mem[raddr];
        end
    end

    // Read strobe and channel tag: strobe pulses per accepted read, tag holds otherwise.
    always_comb begin
        rd_vld_d = rd_acc;
        rd_ch_d  = rd_acc ? rd_sel_i : rd_ch_q;
    end

    // Read side-band registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_ch_q  <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_ch_q  <= rd_ch_d;
        end
    end

    assign rd_dat_o = rd_dat_q;
    assign rd_vld_o = rd_vld_q;
    assign rd_ch_o  = rd_ch_q;

endmodule

// File: tb/tb_vfifo_multi_sc.sv
// Self-checking bench for vfifo_multi_sc: queue-based reference model plus directed and random traffic.
module tb_vfifo_multi_sc;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] wr_dat_i;
    logic        wr_we_i;
    logic [2:0]  wr_sel_i;
    logic        rd_re_i;
    logic [2:0]  rd_sel_i;
    logic [35:0] rd_dat_o;
    logic        rd_vld_o;
    logic [2:0]  rd_ch_o;
    logic [7:0]  flush_i;
    logic [7:0]  fifo_full_o, fifo_afull_o, fifo_empty_o;
    logic [2:0]  lvl_sel_i;
    logic [5:0]  lvl_o;
    logic [7:0]  err_ovf_o, err_udf_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per channel plus expected read-side registers.
    logic [35:0] mq [8][$];
    logic [35:0] exp_dat;
    logic        exp_vld;
    logic [2:0]  exp_ch;
    logic [7:0]  exp_ovf, exp_udf;

    vfifo_multi_sc dut (
        .clk          (clk),
        .rst          (rst),
        .wr_dat_i     (wr_dat_i),
        .wr_we_i      (wr_we_i),
        .wr_sel_i     (wr_sel_i),
        .rd_re_i      (rd_re_i),
        .rd_sel_i     (rd_sel_i),
        .rd_dat_o     (rd_dat_o),
        .rd_vld_o     (rd_vld_o),
        .rd_ch_o      (rd_ch_o),
        .flush_i      (flush_i),
        .fifo_full_o  (fifo_full_o),
        .fifo_afull_o (fifo_afull_o),
        .fifo_empty_o (fifo_empty_o),
        .lvl_sel_i    (lvl_sel_i),
        .lvl_o        (lvl_o),
        .err_ovf_o    (err_ovf_o),
        .err_udf_o    (err_udf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Apply the edge's effect to the model using the inputs currently driven.
    task automatic model_step();
        bit          wa, ra;
        logic [35:0] popped;
        if (rst) begin
            for (int c = 0; c < 8; c++) mq[c].delete();
            exp_dat = '0;
            exp_vld = 1'b0;
            exp_ch  = '0;
            exp_ovf = '0;
            exp_udf = '0;
            return;
        end
        wa = 1'b0;
        ra = 1'b0;
        popped = '0;
        if (wr_we_i && !flush_i[wr_sel_i]) begin
            if (mq[wr_sel_i].size() == 32) exp_ovf[wr_sel_i] = 1'b1;
            else wa = 1'b1;
        end
        if (rd_re_i && !flush_i[rd_sel_i]) begin
            if (mq[rd_sel_i].size() == 0) exp_udf[rd_sel_i] = 1'b1;
            else ra = 1'b1;
        end
        if (ra) popped = mq[rd_sel_i].pop_front();
        if (wa) mq[wr_sel_i].push_back(wr_dat_i);
        for (int c = 0; c < 8; c++) if (flush_i[c]) mq[c].delete();
        exp_vld = ra;
        if (ra) begin
            exp_dat = popped;
            exp_ch  = rd_sel_i;
        end
    endtask

    // Compare every DUT output against the model.
    task automatic check_all();
        logic [7:0] ef, ea, ee;
        for (int c = 0; c < 8; c++) begin
            ef[c] = (mq[c].size() == 32);
            ea[c] = (mq[c].size() >= 28);
            ee[c] = (mq[c].size() == 0);
        end
        chk("rd_vld", 64'(rd_vld_o), 64'(exp_vld));
        chk("rd_dat", 64'(rd_dat_o), 64'(exp_dat));
        chk("rd_ch", 64'(rd_ch_o), 64'(exp_ch));
        chk("full", 64'(fifo_full_o), 64'(ef));
        chk("afull", 64'(fifo_afull_o), 64'(ea));
        chk("empty", 64'(fifo_empty_o), 64'(ee));
        chk("err_ovf", 64'(err_ovf_o), 64'(exp_ovf));
        chk("err_udf", 64'(err_udf_o), 64'(exp_udf));
        chk("lvl", 64'(lvl_o), 64'(mq[lvl_sel_i].size()));
    endtask

    task automatic cyc(input logic r, input logic we, input logic [2:0] ws, input logic [35:0] wd,
                       input logic re, input logic [2:0] rs, input logic [7:0] fl);
        rst       = r;
        wr_we_i   = we;
        wr_sel_i  = ws;
        wr_dat_i  = wd;
        rd_re_i   = re;
        rd_sel_i  = rs;
        flush_i   = fl;
        lvl_sel_i = 3'($urandom_range(0, 7));
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 36'd0, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic lvl_peek(input logic [2:0] ch, input logic [5:0] req, input string name);
        lvl_sel_i = ch;
        #1;
        chk(name, 64'(lvl_o), 64'(req));
    endtask

    initial begin
        rst = 1'b1; wr_dat_i = '0; wr_we_i = 1'b0; wr_sel_i = '0; rd_re_i = 1'b0;
        rd_sel_i = '0; flush_i = '0; lvl_sel_i = '0;
        for (int c = 0; c < 8; c++) mq[c].delete();
        exp_dat = '0; exp_vld = 1'b0; exp_ch = '0; exp_ovf = '0; exp_udf = '0;

        // Reset
        cyc(1'b1, 1'b1, 3'd3, 36'h5, 1'b1, 3'd3, 8'h00);
        cyc(1'b1, 1'b0, 3'd0, 36'h0, 1'b0, 3'd0, 8'h00);
        chk("rst_empty", 64'(fifo_empty_o), 64'hFF);
        chk("rst_full", 64'(fifo_full_o), 64'h0);
        chk("rst_vld", 64'(rd_vld_o), 64'h0);
        for (int c = 0; c < 8; c++) lvl_peek(3'(c), 6'd0, "rst_lvl");

        // Fill ch 5 with 0..31, watching afull/full thresholds
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b1, 3'd5, 36'(i), 1'b0, 3'd0, 8'h00);
            if (i == 26) chk("afull_27", 64'(fifo_afull_o[5]), 64'h0);
            if (i == 27) chk("afull_28", 64'(fifo_afull_o[5]), 64'h1);
            if (i == 30) chk("full_31", 64'(fifo_full_o[5]), 64'h0);
        end
        chk("full_32", 64'(fifo_full_o), 64'h20);
        cyc(1'b0, 1'b1, 3'd5, 36'hABC, 1'b0, 3'd0, 8'h00);
        chk("ovf_33", 64'(err_ovf_o), 64'h20);
        lvl_peek(3'd5, 6'd32, "lvl_full");
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b0, 3'd0, 36'd0, 1'b1, 3'd5, 8'h00);
            chk("drain5", 64'({rd_vld_o, rd_ch_o, rd_dat_o}), 64'({1'b1, 3'd5, 36'(i)}));
        end
        idle();
        chk("vld_drop", 64'(rd_vld_o), 64'h0);

        // Wrap-around on ch 2
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 3'd2, 36'(100 + i), 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 3'd0, 36'd0, 1'b1, 3'd2, 8'h00);
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 3'd2, 36'(200 + i), 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 1'b0, 3'd0, 36'd0, 1'b1, 3'd2, 8'h00);
            chk("wrap2", 64'(rd_dat_o), 64'(200 + i));
        end
        lvl_peek(3'd2, 6'd0, "wrap_lvl");

        // Alternate writes to ch 0 / ch 7 while reading ch 0 every cycle
        for (int i = 0; i < 16; i++)
            cyc(1'b0, 1'b1, (i % 2 == 0) ? 3'd0 : 3'd7, 36'(300 + i), 1'b1, 3'd0, 8'h00);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 3'd0, 36'd0, 1'b1, 3'd7, 8'h00);

        // Simultaneous write and read on ch 0 at count 3
        cyc(1'b0, 1'b0, 3'd0, 36'd0, 1'b0, 3'd0, 8'h01);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 3'd0, 36'(400 + i), 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 1'b1, 3'd0, 36'd403, 1'b1, 3'd0, 8'h00);
        lvl_peek(3'd0, 6'd3, "wr_rd_same");
        chk("wr_rd_dat", 64'(rd_dat_o), 64'd400);

        // Empty-read race on ch 1, then write-to-read turnaround
        cyc(1'b0, 1'b1, 3'd1, 36'h777, 1'b1, 3'd1, 8'h00);
        chk("race_udf", 64'(err_udf_o[1]), 64'h1);
        chk("race_vld", 64'(rd_vld_o), 64'h0);
        cyc(1'b0, 1'b0, 3'd0, 36'd0, 1'b1, 3'd1, 8'h00);
        chk("race_dat", 64'({rd_vld_o, rd_dat_o}), 64'({1'b1, 36'h777}));

        // Flush mid-stream on ch 4 while ch 3 keeps its contents
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 3'd4, 36'(500 + i), 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 3'd3, 36'(600 + i), 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 1'b1, 3'd4, 36'h999, 1'b0, 3'd0, 8'h10);
        chk("flush_empty4", 64'(fifo_empty_o[4]), 64'h1);
        chk("flush_noerr", 64'(err_ovf_o[4] | err_udf_o[4]), 64'h0);
        lvl_peek(3'd3, 6'd5, "flush_lvl3");
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 3'd0, 36'd0, 1'b1, 3'd3, 8'h00);
            chk("flush_dat3", 64'(rd_dat_o), 64'(600 + i));
        end

        // Random traffic with occasional flush and reset
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] fl;
            fl = '0;
            for (int c = 0; c < 8; c++) if ($urandom_range(0, 63) == 0) fl[c] = 1'b1;
            cyc(($urandom_range(0, 999) == 0), ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                {4'($urandom), 32'($urandom)}, ($urandom_range(0, 9) < 4),
                3'($urandom_range(0, 7)), fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vfifo_multi_sc.md
# vfifo_multi_sc

Single-clock, multi-channel FIFO that holds 2**CH_WIDTH independent queues in one shared memory. The memory is addressed as {channel, pointer}. It adds the following over the dual-clock fixed 8×32×36 FIFO:
- width, depth and channel-count parameters
- per-channel fill level and almost-full flag
- per-channel flush
- a read-valid strobe
- sticky overflow/underflow error bits

It sits between the memory controller's Wishbone port arbiters and the SDRAM command/data path wherever both sides run on the same clock.

## Interface
- DATA_WIDTH, 36, word width
- CH_WIDTH, 3, channel select width; NCH = 2**CH_WIDTH channels
- DEPTH_WIDTH, 5, per-channel depth 2**DEPTH_WIDTH entries
- AFULL_LVL, 28, almost-full threshold (entries); legal range 1..2**DEPTH_WIDTH

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- wr_dat_i  in  DATA_WIDTH  write data
- wr_we_i  in  1  write request
- wr_sel_i  in  CH_WIDTH  write channel
- rd_re_i  in  1  read request
- rd_sel_i  in  CH_WIDTH  read channel
- rd_dat_o  out  DATA_WIDTH  read data, registered
- rd_vld_o  out  1  rd_dat_o holds a newly read word this cycle
- rd_ch_o  out  CH_WIDTH  channel of the word on rd_dat_o
- flush_i  in  NCH  per-channel flush
- fifo_full_o  out  NCH  count == 2**DEPTH_WIDTH
- fifo_afull_o  out  NCH  count >= AFULL_LVL
- fifo_empty_o  out  NCH  count == 0
- lvl_sel_i  in  CH_WIDTH  level query channel
- lvl_o  out  DEPTH_WIDTH+1  count of channel lvl_sel_i, combinational
- err_ovf_o  out  NCH  sticky: write attempted to full channel
- err_udf_o  out  NCH  sticky: read attempted from empty channel

## Operation
**Per-channel state.** Each channel keeps:
- wptr and rptr, DEPTH_WIDTH-bit binary, wrapping naturally 2**DEPTH_WIDTH-1 → 0
- cnt, DEPTH_WIDTH+1 bits

**Flags.** All status flags decode cnt registers only; there are no bypass paths.

**Write.**
- Accepted iff wr_we_i & !fifo_full_o[wr_sel_i] & !flush_i[wr_sel_i].
- On accept: mem[{wr_sel_i, wptr}] <= wr_dat_i; wptr++.

**Read.**
- Accepted iff rd_re_i & !fifo_empty_o[rd_sel_i] & !flush_i[rd_sel_i].
- On accept: rd_dat_o <= mem[{rd_sel_i, rptr}]; rptr++; rd_ch_o <= rd_sel_i; rd_vld_o <= 1.
- Otherwise rd_vld_o <= 0, and rd_dat_o and rd_ch_o hold their values.

**Count update.**
- cnt +1 on accepted write only.
- cnt −1 on accepted read only.
- cnt unchanged when both are accepted on the same channel.
- Different channels update independently in the same cycle.

**Rejection on flags.**
- Full and empty are evaluated on the pre-edge state.
- A write to a full channel is rejected even if a read of that channel is accepted in the same cycle.
- A read from an empty channel is rejected even if a write to that channel is accepted in the same cycle.

**Errors.**
- A rejected write due to full sets err_ovf_o[ch].
- A rejected read due to empty sets err_udf_o[ch].
- Both bits clear only on rst.
- Rejections caused by flush do not set error bits.

**Flush.**
- flush_i[ch] sets wptr, rptr and cnt of ch to 0 at the next edge.
- It has priority over a same-cycle write or read on ch.
- Memory contents are not cleared.
- Other channels are unaffected.

**Reset.** When rst = 1, at the next edge:
- all pointers and counts go to 0
- rd_dat_o = 0, rd_vld_o = 0, rd_ch_o = 0
- err bits = 0
- fifo_empty_o = all ones; fifo_full_o = 0; fifo_afull_o = 0
- rst takes priority over every request, including in the middle of a burst.
- Memory contents are undefined after reset and are never observable.

## Timing
- Read latency is 1 cycle: request at edge N, then rd_dat_o and rd_vld_o are valid after edge N+1 for exactly one cycle per accepted read.
- Back-to-back reads, including alternating channels, sustain 1 word/cycle.
- Flags and lvl_o reflect a write or read 1 cycle after the accepting edge.
- Write-to-read turnaround: a word written at edge N is readable by a request at edge N+1 and appears on rd_dat_o after edge N+2.
- No combinational path from wr_* or rd_* inputs to any output except lvl_o, which depends on lvl_sel_i only.

## Structure
- Default parameter values and the NCH derivation go in versatile_mem_ctrl_defines.v, shared with the other FIFO variants.
- Sub-module fifo_ch_ctrl, instantiated NCH times in a generate loop:
  - contains wptr, rptr, cnt, full/afull/empty decode and sticky error bits
  - inputs: we, re, flush, clk, rst
  - outputs: wptr, rptr, flags
- Memory is an inferred 2**(CH_WIDTH+DEPTH_WIDTH) × DATA_WIDTH array in the top, with a synchronous read port, so it maps to block RAM.

## Test plan
- **Reset:** hold rst 2 cycles → fifo_empty_o = 8'hFF, fifo_full_o = 0, rd_vld_o = 0, lvl_o = 0 for every lvl_sel_i.
- **Fill and drain:**
  - Write 32 words 0..31 to ch 5 → fifo_afull_o[5] rises after word 28 and fifo_full_o[5] after word 32.
  - A 33rd write sets err_ovf_o[5] and is discarded.
  - Then 32 reads return 0..31 in order with rd_ch_o = 5.
- **Wrap-around:** on ch 2, write 20 words, read 20, then write 30 and read 30 → data is in order across the pointer wrap and lvl_o ends at 0.
- **Interleaving and simultaneity:**
  - Alternate writes to ch 0 and ch 7 while reading ch 0 each cycle → each channel's sequence is intact.
  - A same-cycle write and read on ch 0 with cnt = 3 leaves cnt = 3.
- **Empty-read race:** on empty ch 1, issue a write and a read in the same cycle → read rejected, err_udf_o[1] = 1, and the next-cycle read returns the word.
- **Flush mid-stream:** ch 4 holds 10 words and ch 3 holds 5; assert flush_i[4] together with a write to ch 4 → ch 4 empty, no error set, ch 3 still has lvl = 5 and intact data.
